// File: rtl/lcd_value_formatter_if.sv
// Bus between lcd_value_formatter and its neighbours: value/update requests in,
// a 34-char frame plus start pulse out toward lcd_init.
interface lcd_value_formatter_if #(
  parameter int TEXT_LENGTH = 34
);
  // Handshake: update is level or pulse; a request made while busy is held
  // single-deep and values are sampled when the idle FSM consumes it.
  // sendText is a one-cycle start pulse; text stays frozen from that pulse
  // until sendingDone is seen after the mandatory gap.
  logic [15:0]              value_a;
  logic [15:0]              value_b;
  logic                     update;
  logic                     sendingDone;
  logic [8*TEXT_LENGTH-1:0] text;
  logic                     sendText;
  logic                     busy;

  modport master (
    output value_a, value_b, update, sendingDone,
    input  text, sendText, busy
  );

  modport slave (
    input  value_a, value_b, update, sendingDone,
    output text, sendText, busy
  );
endinterface

// File: rtl/lcd_value_formatter.sv
// Converts two 16-bit values to blank-padded decimal and lays them out as a
// two-line LCD frame, then kicks lcd_init and holds the frame until it finishes.
module lcd_value_formatter #(
  parameter int TEXT_LENGTH = 34,
  parameter int SEND_GAP    = 1_000_000,
  parameter int GAP_W       = 21
) (
  input  logic                 CLK,
  input  logic                 RST,
  lcd_value_formatter_if.slave bus,
  output logic [2:0]           dbgState
);

  typedef enum logic [2:0] {IDLE, CONV_A, CONV_B, BUILD, SEND, WAIT} state_t;

  localparam logic [8*TEXT_LENGTH-1:0] BLANK_FRAME =
    {8'h0A, {16{8'h20}}, 8'h0A, {16{8'h20}}};

  state_t             state;
  logic [35:0]        shiftReg;
  logic [35:0]        shiftNext;
  logic [19:0]        bcdA;
  logic [15:0]        valueB;
  logic [3:0]         iter;
  logic [GAP_W-1:0]   gapCnt;
  logic               pending;

  // One double-dabble step: correct every BCD digit >= 5, then shift left.
  function automatic logic [35:0] shiftAdd3(input logic [35:0] s);
    logic [35:0] r;
    r = s;
    for (int d = 0; d < 5; d++) begin
      if (r[16+4*d +: 4] >= 4'd5)
        r[16+4*d +: 4] = r[16+4*d +: 4] + 4'd3;
    end
    return {r[34:0], 1'b0};
  endfunction

  // "X=" followed by five digits with leading zeros blanked, then space padding.
  function automatic logic [127:0] fmtLine(input logic [7:0] tag, input logic [19:0] bcd);
    logic [127:0] l;
    logic         lead;
    l          = {16{8'h20}};
    l[127:120] = tag;
    l[119:112] = 8'h3D;
    lead       = 1'b1;
    for (int d = 4; d >= 0; d--) begin
      if (bcd[4*d +: 4] != 4'd0 || d == 0)
        lead = 1'b0;
      if (!lead)
        l[111-8*(4-d) -: 8] = {4'h3, bcd[4*d +: 4]};
    end
    return l;
  endfunction

  assign shiftNext = shiftAdd3(shiftReg);
  assign dbgState  = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      bus.sendText <= 1'b0;
      bus.busy     <= 1'b0;
      bus.text     <= BLANK_FRAME;
      pending      <= 1'b0;
      gapCnt       <= '0;
      shiftReg     <= '0;
      bcdA         <= '0;
      valueB       <= '0;
      iter         <= '0;
    end else begin
      bus.sendText <= 1'b0;
      if (bus.update && state != IDLE)
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.update || pending) begin
            valueB   <= bus.value_b;
            shiftReg <= {20'd0, bus.value_a};
            pending  <= 1'b0;
            iter     <= '0;
            bus.busy <= 1'b1;
            state    <= CONV_A;
          end
        end
        CONV_A: begin
          iter <= iter + 4'd1;
          if (iter == 4'd15) begin
            bcdA     <= shiftNext[35:16];
            shiftReg <= {20'd0, valueB};
            state    <= CONV_B;
          end else begin
            shiftReg <= shiftNext;
          end
        end
        CONV_B: begin
          iter     <= iter + 4'd1;
          shiftReg <= shiftNext;
          if (iter == 4'd15)
            state <= BUILD;
        end
        BUILD: begin
          bus.text <= {8'h0A, fmtLine(8'h41, bcdA), 8'h0A, fmtLine(8'h42, shiftReg[35:16])};
          state    <= SEND;
        end
        SEND: begin
          bus.sendText <= 1'b1;
          gapCnt       <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          // sendingDone is sticky, so only the gap makes the completion check meaningful.
          if (gapCnt != GAP_W'(SEND_GAP))
            gapCnt <= gapCnt + GAP_W'(1);
          if (gapCnt == GAP_W'(SEND_GAP) && bus.sendingDone) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Randomized bench for lcd_value_formatter with a numeric reference of the frame layout.
module tb_lcd_value_formatter;

  localparam int TL       = 34;
  localparam int SEND_GAP = 40;
  localparam int W        = 8*TL;

  logic       CLK;
  logic       RST;
  logic [2:0] dbgState;

  lcd_value_formatter_if #(.TEXT_LENGTH(TL)) bus();

  lcd_value_formatter #(
    .TEXT_LENGTH(TL),
    .SEND_GAP   (SEND_GAP),
    .GAP_W      (21)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus.slave),
    .dbgState(dbgState)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  int sendCount = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] blankFrame;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [127:0] ref_line(input logic [7:0] tag, input int v);
    logic [7:0]   ch [16];
    logic [127:0] l;
    int           p;
    for (int i = 0; i < 16; i++) ch[i] = 8'h20;
    ch[0] = tag;
    ch[1] = 8'h3D;
    p = 10000;
    for (int k = 0; k < 5; k++) begin
      if (v >= p || p == 1) ch[2+k] = 8'h30 + 8'((v / p) % 10);
      p = p / 10;
    end
    for (int i = 0; i < 16; i++) l[127-8*i -: 8] = ch[i];
    return l;
  endfunction

  function automatic logic [W-1:0] ref_frame(input int a, input int b);
    return {8'h0A, ref_line(8'h41, a), 8'h0A, ref_line(8'h42, b)};
  endfunction

  // scoreboard: every start pulse must match the oldest expected frame
  always @(negedge CLK) begin
    if (!RST && bus.sendText) begin
      sendCount++;
      if (exp_q.size() == 0) check("unexpected_send", 1, 0);
      else                   check("frame", bus.text, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic pulse_update(input int a, input int b);
    bus.value_a = 16'(a);
    bus.value_b = 16'(b);
    bus.update  = 1'b1;
    @(negedge CLK);
    bus.update  = 1'b0;
  endtask

  task automatic send_values(input int a, input int b);
    int n;
    @(negedge CLK);
    exp_q.push_back(ref_frame(a, b));
    pulse_update(a, b);
    n = 1;
    while (!bus.sendText && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("latency", W'(n), W'(35));
    @(negedge CLK);
    check("pulse_width", W'(bus.sendText), W'(0));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 3*SEND_GAP + 100) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", W'(bus.busy), W'(0));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int a, b, base, n;
    logic [W-1:0] held;
    blankFrame = {8'h0A, {16{8'h20}}, 8'h0A, {16{8'h20}}};
    RST = 1'b1;
    bus.update = 1'b0;
    bus.value_a = '0;
    bus.value_b = '0;
    bus.sendingDone = 1'b0;

    // reset frame
    do_reset();
    check("rst_text", bus.text, blankFrame);
    check("rst_send", W'(bus.sendText), W'(0));
    check("rst_busy", W'(bus.busy), W'(0));
    bus.sendingDone = 1'b1;

    // directed values incl. extremes and blanking
    send_values(12345, 0);  wait_idle();
    send_values(65535, 7);  wait_idle();
    send_values(100, 7);    wait_idle();
    send_values(10, 9);     wait_idle();

    // random values, half of them small to exercise blanking
    for (int i = 0; i < 8; i++) begin
      a = (i % 2) ? $urandom_range(0, 99) : $urandom_range(0, 65535);
      b = (i % 2) ? $urandom_range(0, 65535) : $urandom_range(0, 999);
      send_values(a, b);
      wait_idle();
    end

    // requests during WAIT collapse into one refresh with values sampled late
    send_values(1111, 2222);
    held = bus.text;
    base = sendCount;
    for (int i = 0; i < 3; i++) begin
      pulse_update($urandom_range(0, 65535), $urandom_range(0, 65535));
      repeat (3) @(negedge CLK);
      check("hold_text", bus.text, held);
    end
    a = $urandom_range(0, 65535);
    b = $urandom_range(0, 65535);
    bus.value_a = 16'(a);
    bus.value_b = 16'(b);
    exp_q.push_back(ref_frame(a, b));
    repeat (SEND_GAP - 20) @(negedge CLK);
    check("hold_late", bus.text, held);
    n = 0;
    while (!bus.sendText && n < SEND_GAP + 100) begin
      @(negedge CLK);
      n++;
    end
    check("refresh_seen", W'(bus.sendText), W'(1));
    @(negedge CLK);
    wait_idle();
    repeat (2*SEND_GAP) @(negedge CLK);
    check("one_refresh", W'(sendCount - base), W'(1));

    // sendingDone never arrives: stuck in WAIT, no further start pulses
    bus.sendingDone = 1'b0;
    do_reset();
    send_values(500, 65000);
    base = sendCount;
    repeat (SEND_GAP) @(negedge CLK);
    pulse_update(3, 4);
    repeat (SEND_GAP + 20) @(negedge CLK);
    check("stuck_busy", W'(bus.busy), W'(1));
    check("stuck_nosend", W'(sendCount), W'(base));

    // reset during the second conversion abandons the refresh
    do_reset();
    bus.sendingDone = 1'b1;
    @(negedge CLK);
    pulse_update(4321, 8765);
    repeat (24) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst_text", bus.text, blankFrame);
    check("midrst_send", W'(bus.sendText), W'(0));
    check("midrst_busy", W'(bus.busy), W'(0));
    @(negedge CLK);
    RST = 1'b0;
    base = sendCount;
    repeat (100) @(negedge CLK);
    check("midrst_nosend", W'(sendCount), W'(base));
    check("midrst_idle", W'(bus.busy), W'(0));
    send_values(4321, 8765);
    wait_idle();
    check("queue_empty", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
